ram16_seq_ctrl: RTL and testbench

Sequencer and host-write arbiter wrapped around the existing 16×10 `ram16` pulse table in the radar FPGA. It accepts host table writes and, on trigger, plays the table back: entries 0..N-1 in order, each held for its stored dwell in clocks. It drives per-entry step strobes to the downstream pulse/window logic. It also keeps host writes from landing in the table while playback is in progress.

---
 rtl/gnuradar_seq_pkg.sv | 7 +
 rtl/ram16.sv | 18 +
 rtl/ram16_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_ram16_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gnuradar_seq_pkg.sv
// gnuradar_seq_pkg: shared state encoding and default sizes for the pulse-table sequencer
package gnuradar_seq_pkg;
  localparam int DEPTH_DEF  = 10;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, FETCH, RUN} state_t;
endpackage

// File: rtl/ram16.sv
// ram16: 16-entry pulse table, synchronous write port and registered read port
module ram16 #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ram16_seq_ctrl.sv
// ram16_seq_ctrl: plays the pulse table back on trigger and holds off host writes during playback
module ram16_seq_ctrl import gnuradar_seq_pkg::*; #(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  output logic              host_busy,
  output logic              host_err,
  input  logic [ADDR_W-1:0] cfg_num,
  input  logic              seq_trig,
  input  logic              seq_abort,
  output logic              seq_active,
  output logic [ADDR_W-1:0] seq_index,
  output logic [DATA_W-1:0] seq_dwell,
  output logic              seq_step,
  output logic              seq_done,
  output logic              seq_err
);
  state_t state_q, state_d;
  logic pend_q, pend_d, first_q, first_d, done_q, done_d, serr_q, serr_d, herr_q, herr_d;
  logic [ADDR_W-1:0] num_q, num_d, idx_q, idx_d;
  logic [DATA_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic w_v_q, w_v_d;
  logic [ADDR_W-1:0] w_a_q, w_a_d;
  logic [DATA_W-1:0] w_dat_q, w_dat_d;
  logic idle, we, cfg_ok, trig_ok, wr_ok, last;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data, rem;

  ram16 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clock(clock), .we(we), .wr_addr(w_a_q), .wr_data(w_dat_q),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // One write register serves both the IDLE commit pipeline and the playback hold
  assign idle      = state_q == IDLE;
  assign we        = w_v_q && idle;
  assign host_busy = w_v_q && !idle;
  assign host_ack  = we;
  assign host_err  = herr_q;
  assign cfg_ok    = cfg_num != '0 && int'(cfg_num) <= DEPTH;
  assign trig_ok   = idle && !pend_q && seq_trig && cfg_ok;
  assign wr_ok     = host_wr && !host_busy && int'(host_addr) < DEPTH;
  assign rd_addr   = (state_q == FETCH) ? '0 : idx_q + 1'b1;
  assign rem       = first_q ? ((rd_data == '0) ? '0 : rd_data - 1'b1) : cnt_q;
  assign last      = idx_q == num_q - 1'b1;
  assign seq_active = !idle;
  assign seq_index  = idx_q;
  assign seq_step   = state_q == RUN && first_q;
  assign seq_dwell  = seq_step ? rd_data : dwell_q;
  assign seq_done   = done_q;
  assign seq_err    = serr_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    num_d   = num_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    first_d = 1'b0;
    done_d  = 1'b0;
    serr_d  = idle && !pend_q && seq_trig && !cfg_ok;
    herr_d  = host_wr && !wr_ok;
    w_v_d   = wr_ok || (w_v_q && !we);
    w_a_d   = wr_ok ? host_addr : w_a_q;
    w_dat_d = wr_ok ? host_data : w_dat_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = FETCH;
          pend_d  = 1'b0;
        end else if (trig_ok) begin
          num_d   = cfg_num;
          pend_d  = we;
          state_d = we ? IDLE : FETCH;
        end
      end
      FETCH: begin
        idx_d   = '0;
        first_d = !seq_abort;
        state_d = seq_abort ? IDLE : RUN;
      end
      RUN: begin
        if (first_q) dwell_d = rd_data;
        if (seq_abort) state_d = IDLE;
        else if (rem != '0) cnt_d = rem - 1'b1;
        else if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 1'b1;
          first_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
      herr_q  <= 1'b0;
      num_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      w_v_q   <= 1'b0;
      w_a_q   <= '0;
      w_dat_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      herr_q  <= herr_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      w_v_q   <= w_v_d;
      w_a_q   <= w_a_d;
      w_dat_q <= w_dat_d;
    end
  end
endmodule

// File: tb/tb_ram16_seq_ctrl.sv
// tb_ram16_seq_ctrl: directed and randomized playback checks against a table-level reference model
module tb_ram16_seq_ctrl;
  logic clock, reset, host_wr, seq_trig, seq_abort;
  logic [3:0] host_addr, cfg_num, seq_index;
  logic [15:0] host_data, seq_dwell;
  logic host_ack, host_busy, host_err, seq_active, seq_step, seq_done, seq_err;
  int checks = 0;
  int failures = 0;
  int mem_m [16];

  ram16_seq_ctrl dut (
    .clock(clock), .reset(reset), .host_wr(host_wr), .host_addr(host_addr),
    .host_data(host_data), .host_ack(host_ack), .host_busy(host_busy), .host_err(host_err),
    .cfg_num(cfg_num), .seq_trig(seq_trig), .seq_abort(seq_abort), .seq_active(seq_active),
    .seq_index(seq_index), .seq_dwell(seq_dwell), .seq_step(seq_step), .seq_done(seq_done),
    .seq_err(seq_err)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_write(input int a, input int d);
    host_addr = 4'(a);
    host_data = 16'(d);
    host_wr = 1;
    tick;
    host_wr = 0;
    chk("wr_ack", host_ack, 1);
    chk("wr_busy", host_busy, 0);
    mem_m[a] = d;
    tick;
  endtask

  task automatic go(input int n);
    cfg_num = 4'(n);
    seq_trig = 1;
    tick;
    seq_trig = 0;
  endtask

  // Current sample is the cycle after the trigger edge; pre adds idle cycles before FETCH
  task automatic run_check(input int n, input int pre, input string tag);
    int st[$];
    int acc, total, e;
    acc = 2;
    for (int i = 0; i < n; i++) begin
      st.push_back(acc + pre);
      acc += (mem_m[i] == 0) ? 1 : mem_m[i];
    end
    total = acc - 2;
    e = 0;
    for (int t = 1; t <= 2 + total + pre; t++) begin
      logic exp_step;
      exp_step = e < n && st[e] == t;
      chk({tag, "_active"}, seq_active, t > pre && t <= 1 + total + pre);
      chk({tag, "_done"}, seq_done, t == 2 + total + pre);
      chk({tag, "_step"}, seq_step, exp_step);
      if (exp_step) begin
        chk({tag, "_index"}, seq_index, e);
        chk({tag, "_dwell"}, seq_dwell, mem_m[e]);
        e++;
      end
      if (t < 2 + total + pre) tick;
    end
  endtask

  initial begin
    reset = 0; host_wr = 0; host_addr = 0; host_data = 0;
    cfg_num = 0; seq_trig = 0; seq_abort = 0;
    #2 reset = 1;
    repeat (2) @(negedge clock);
    chk("rst_active", seq_active, 0);
    chk("rst_index", seq_index, 0);
    chk("rst_dwell", seq_dwell, 0);
    chk("rst_busy", host_busy, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_pulses", {seq_step, seq_done, seq_err, host_err}, 0);
    reset = 0;
    tick;

    do_write(0, 3);
    do_write(1, 1);
    do_write(2, 0);
    for (int a = 3; a < 10; a++) do_write(a, $urandom_range(0, 6));

    go(3);
    run_check(3, 0, "basic");
    tick;

    go(3);
    tick;
    host_addr = 1; host_data = 7; host_wr = 1;
    tick;
    host_wr = 0;
    chk("run_wr_busy", host_busy, 1);
    chk("run_wr_noack", host_ack, 0);
    host_addr = 2; host_data = 9; host_wr = 1;
    tick;
    host_wr = 0;
    chk("busy_wr_err", host_err, 1);
    for (int k = 0; k < 20 && seq_active; k++) begin
      chk("hold_busy", host_busy, 1);
      tick;
    end
    chk("hold_end_idle", seq_active, 0);
    chk("hold_flush_ack", host_ack, 1);
    chk("hold_flush_busy", host_busy, 0);
    mem_m[1] = 7;
    tick;
    go(3);
    run_check(3, 0, "after_hold");
    tick;

    host_addr = 0; host_data = 5; host_wr = 1;
    tick;
    host_wr = 0;
    chk("simul_ack", host_ack, 1);
    cfg_num = 3; seq_trig = 1;
    tick;
    seq_trig = 0;
    mem_m[0] = 5;
    run_check(3, 1, "simul");
    tick;

    go(0);
    chk("rej0_err", seq_err, 1);
    chk("rej0_idle", seq_active, 0);
    tick;
    chk("rej0_err_clr", seq_err, 0);
    chk("rej0_still_idle", seq_active, 0);
    go(11);
    chk("rej11_err", seq_err, 1);
    chk("rej11_idle", seq_active, 0);
    tick;
    chk("rej11_still_idle", seq_active, 0);
    host_addr = 10; host_data = 16'h55; host_wr = 1;
    tick;
    host_wr = 0;
    chk("badaddr_err", host_err, 1);
    chk("badaddr_noack", host_ack, 0);
    tick;
    chk("badaddr_noack2", host_ack, 0);
    chk("badaddr_err_clr", host_err, 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      for (int j = 0; j < 4; j++) do_write($urandom_range(0, 9), $urandom_range(0, 5));
      n = $urandom_range(1, 10);
      go(n);
      run_check(n, 0, "rand");
      tick;
    end

    do_write(0, 100);
    go(2);
    repeat (40) tick;
    chk("abort_pre_index", seq_index, 0);
    chk("abort_pre_active", seq_active, 1);
    seq_abort = 1;
    tick;
    seq_abort = 0;
    chk("abort_idle", seq_active, 0);
    chk("abort_nodone", seq_done, 0);
    tick;
    chk("abort_nodone2", seq_done, 0);
    go(2);
    run_check(2, 0, "reabort");
    tick;

    go(3);
    tick;
    host_addr = 2; host_data = 16'h1234; host_wr = 1;
    tick;
    host_wr = 0;
    chk("rst_hold_busy", host_busy, 1);
    reset = 1;
    #1;
    chk("midrst_active", seq_active, 0);
    chk("midrst_busy", host_busy, 0);
    chk("midrst_index", seq_index, 0);
    chk("midrst_dwell", seq_dwell, 0);
    chk("midrst_pulses", {seq_step, seq_done, host_ack}, 0);
    @(negedge clock);
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("postrst_noack", host_ack, 0);
    end
    go(3);
    run_check(3, 0, "post_rst");
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
